// File: rtl/sdram_rd_streamer_pkg.sv
// Shared constants for the SDRAM read-side streamer: default widths, skid buffer
// geometry and the position-counter width helper.
package sdram_rd_streamer_pkg;

   localparam int unsigned DEFAULT_DATA_W   = 16;
   localparam int unsigned DEFAULT_LINE_LEN = 640;
   localparam int unsigned DEFAULT_LINE_NUM = 480;

   localparam int unsigned SKID_DEPTH = 3;
   localparam int unsigned OCC_W      = 2;
   localparam int unsigned PTR_W      = 2;

   // Counter width for a modulo-limit counter, never narrower than one bit.
   function automatic int unsigned cnt_w(input int unsigned limit);
      return (limit <= 2) ? 1 : $clog2(limit);
   endfunction

endpackage

// File: rtl/sdram_skid_buf3.sv
// Three-entry circular skid buffer absorbing the FIFO's one-cycle read latency
// so the stream can run at full rate while the sink back-pressures.
module sdram_skid_buf3
   import sdram_rd_streamer_pkg::*;
#(
   parameter int unsigned DATA_W = DEFAULT_DATA_W
)
(
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              push_i,
   input  logic [DATA_W-1:0] push_data_i,
   input  logic              pop_i,
   output logic [DATA_W-1:0] head_o,
   output logic [OCC_W-1:0]  occ_o
);

   localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(SKID_DEPTH);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(SKID_DEPTH - 1);

   logic [DATA_W-1:0] mem_q [SKID_DEPTH];
   logic [PTR_W-1:0]  head_q, head_d;
   logic [PTR_W-1:0]  tail_q, tail_d;
   logic [OCC_W-1:0]  occ_q, occ_d;
   logic              do_push, do_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
   endfunction

   // Pointer/occupancy update; a push into a full buffer is only taken alongside a pop.
   always_comb begin
      do_pop  = pop_i & (occ_q != '0);
      do_push = push_i & ((occ_q != OCC_FULL) | do_pop);
      head_d  = do_pop  ? ptr_inc(head_q) : head_q;
      tail_d  = do_push ? ptr_inc(tail_q) : tail_q;
      occ_d   = occ_q;
      if (do_push && !do_pop) begin
         occ_d = occ_q + OCC_W'(1);
      end else if (do_pop && !do_push) begin
         occ_d = occ_q - OCC_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         head_q <= '0;
         tail_q <= '0;
         occ_q  <= '0;
         for (int i = 0; i < int'(SKID_DEPTH); i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
         occ_q  <= occ_d;
         if (do_push) begin
            mem_q[tail_q] <= push_data_i;
         end
      end
   end

   assign head_o = mem_q[head_q];
   assign occ_o  = occ_q;

endmodule

// File: rtl/sdram_rd_streamer.sv
// Drains the read-side FIFO into a valid/ready pixel stream, tagging start of
// frame / end of line and pulsing frame_done after each complete frame.
module sdram_rd_streamer
   import sdram_rd_streamer_pkg::*;
#(
   parameter int unsigned DATA_W   = DEFAULT_DATA_W,
   parameter int unsigned LINE_LEN = DEFAULT_LINE_LEN,
   parameter int unsigned LINE_NUM = DEFAULT_LINE_NUM
)
(
   input  logic              r_clk,
   input  logic              rst,
   input  logic              enable,
   input  logic              fifo_empty,
   output logic              fifo_ren,
   input  logic [DATA_W-1:0] fifo_dout,
   output logic [DATA_W-1:0] m_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic              m_sof,
   output logic              m_eol,
   output logic              frame_done
);

   localparam int unsigned PIX_W  = cnt_w(LINE_LEN);
   localparam int unsigned LINE_W = cnt_w(LINE_NUM);
   localparam logic [PIX_W-1:0]  PIX_LAST  = PIX_W'(LINE_LEN - 1);
   localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(LINE_NUM - 1);

   logic [OCC_W-1:0]  occ;
   logic              inflight_q;
   logic              xfer;
   logic [PIX_W-1:0]  pix_q, pix_d;
   logic [LINE_W-1:0] line_q, line_d;
   logic              frame_done_q, frame_done_d;

   // Issue a read only when the returning word is guaranteed a free slot.
   assign fifo_ren = ~rst & enable & ~fifo_empty &
                     ((3'(occ) + 3'(inflight_q)) <= 3'd2);

   sdram_skid_buf3 #(
      .DATA_W (DATA_W)
   ) u_buf (
      .clk_i       (r_clk),
      .rst_i       (rst),
      .push_i      (inflight_q),
      .push_data_i (fifo_dout),
      .pop_i       (m_ready),
      .head_o      (m_data),
      .occ_o       (occ)
   );

   assign m_valid    = (occ != '0);
   assign xfer       = m_valid & m_ready;
   assign m_sof      = m_valid & (pix_q == '0) & (line_q == '0);
   assign m_eol      = m_valid & (pix_q == PIX_LAST);
   assign frame_done = frame_done_q;

   // Raster position advances only on accepted words.
   always_comb begin
      pix_d        = pix_q;
      line_d       = line_q;
      frame_done_d = 1'b0;
      if (xfer) begin
         if (pix_q == PIX_LAST) begin
            pix_d = '0;
            if (line_q == LINE_LAST) begin
               line_d       = '0;
               frame_done_d = 1'b1;
            end else begin
               line_d = line_q + LINE_W'(1);
            end
         end else begin
            pix_d = pix_q + PIX_W'(1);
         end
      end
   end

   always_ff @(posedge r_clk) begin
      if (rst) begin
         inflight_q   <= 1'b0;
         pix_q        <= '0;
         line_q       <= '0;
         frame_done_q <= 1'b0;
      end else begin
         inflight_q   <= fifo_ren;
         pix_q        <= pix_d;
         line_q       <= line_d;
         frame_done_q <= frame_done_d;
      end
   end

endmodule

// File: tb/tb_sdram_rd_streamer.sv
// Directed bench for sdram_rd_streamer with a 4x2 frame and a behavioural
// 1-cycle-latency FIFO model.
module tb_sdram_rd_streamer;

   logic        r_clk = 1'b0;
   logic        rst, enable, fifo_empty, fifo_ren, m_valid, m_ready;
   logic        m_sof, m_eol, frame_done;
   logic [15:0] fifo_dout = 16'h0;
   logic [15:0] m_data;

   logic [15:0] fmem [256];
   int          wr_ptr  = 0;
   int          rd_ptr  = 0;
   int          pop_cnt = 0;
   int          errors  = 0;
   int          checks  = 0;

   always #5 r_clk = ~r_clk;

   sdram_rd_streamer #(
      .DATA_W   (16),
      .LINE_LEN (4),
      .LINE_NUM (2)
   ) dut (
      .r_clk      (r_clk),
      .rst        (rst),
      .enable     (enable),
      .fifo_empty (fifo_empty),
      .fifo_ren   (fifo_ren),
      .fifo_dout  (fifo_dout),
      .m_data     (m_data),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_sof      (m_sof),
      .m_eol      (m_eol),
      .frame_done (frame_done)
   );

   // Standard FIFO: data appears the cycle after an accepted read.
   assign fifo_empty = (wr_ptr == rd_ptr);
   always @(posedge r_clk) begin
      if (fifo_ren) begin
         if (wr_ptr != rd_ptr) begin
            fifo_dout <= fmem[rd_ptr[7:0]];
            rd_ptr    <= rd_ptr + 1;
         end else begin
            fifo_dout <= 16'hDEAD;
         end
         pop_cnt <= pop_cnt + 1;
      end
   end

   task automatic drive(input logic rs, input logic en, input logic rdy,
                        input int npush, input logic [15:0] base);
      @(negedge r_clk);
      rst     = rs;
      enable  = en;
      m_ready = rdy;
      for (int i = 0; i < npush; i++) begin
         fmem[wr_ptr[7:0]] = base + 16'(i);
         wr_ptr++;
      end
      #1;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0, 0, 16'h0);
      checks++; if (fifo_ren !== 1'b0)    begin errors++; $display("FAIL reset_ren: got %b expected 0", fifo_ren); end
      checks++; if (m_valid !== 1'b0)     begin errors++; $display("FAIL reset_valid: got %b expected 0", m_valid); end
      checks++; if (m_data !== 16'h0)     begin errors++; $display("FAIL reset_data: got %h expected 0000", m_data); end
      checks++; if (m_sof !== 1'b0)       begin errors++; $display("FAIL reset_sof: got %b expected 0", m_sof); end
      checks++; if (m_eol !== 1'b0)       begin errors++; $display("FAIL reset_eol: got %b expected 0", m_eol); end
      checks++; if (frame_done !== 1'b0)  begin errors++; $display("FAIL reset_fd: got %b expected 0", frame_done); end
   endtask

   task automatic test_stream();
      logic        e_ren, e_val, e_sof, e_eol, e_fd;
      logic [15:0] e_data;
      drive(1'b1, 1'b1, 1'b1, 8, 16'h0001);
      checks++; if (fifo_ren !== 1'b0) begin errors++; $display("FAIL stream_ren_in_rst: got %b expected 0", fifo_ren); end
      for (int c = 0; c < 12; c++) begin
         drive(1'b0, 1'b1, 1'b1, 0, 16'h0);
         e_ren  = (c <= 7);
         e_val  = (c >= 2) && (c <= 9);
         e_data = 16'(c - 1);
         e_sof  = (c == 2);
         e_eol  = (c == 5) || (c == 9);
         e_fd   = (c == 10);
         checks++; if (fifo_ren !== e_ren) begin errors++; $display("FAIL stream_ren c=%0d: got %b expected %b", c, fifo_ren, e_ren); end
         checks++; if (m_valid !== e_val)  begin errors++; $display("FAIL stream_valid c=%0d: got %b expected %b", c, m_valid, e_val); end
         if (e_val) begin
            checks++; if (m_data !== e_data) begin errors++; $display("FAIL stream_data c=%0d: got %h expected %h", c, m_data, e_data); end
         end
         checks++; if (m_sof !== e_sof)     begin errors++; $display("FAIL stream_sof c=%0d: got %b expected %b", c, m_sof, e_sof); end
         checks++; if (m_eol !== e_eol)     begin errors++; $display("FAIL stream_eol c=%0d: got %b expected %b", c, m_eol, e_eol); end
         checks++; if (frame_done !== e_fd) begin errors++; $display("FAIL stream_fd c=%0d: got %b expected %b", c, frame_done, e_fd); end
      end
   endtask

   task automatic test_stall();
      int          p0, k, outst, fd_cnt;
      logic        rdy, prev_stall;
      logic [15:0] prev_data;
      p0 = pop_cnt; k = 0; fd_cnt = 0; prev_stall = 1'b0; prev_data = 16'h0;
      for (int c = 0; c < 100 && k < 8; c++) begin
         rdy = ((c % 4) == 0) || ((c % 4) == 3);
         drive(1'b0, 1'b1, rdy, (c == 0) ? 8 : 0, 16'h0009);
         outst = pop_cnt - p0 - k;
         checks++; if (outst > 3) begin errors++; $display("FAIL stall_occ c=%0d: got %0d expected <=3", c, outst); end
         if (outst == 3) begin
            checks++; if (fifo_ren !== 1'b0) begin errors++; $display("FAIL stall_ren_full c=%0d: got %b expected 0", c, fifo_ren); end
         end
         if (prev_stall) begin
            checks++; if (m_valid !== 1'b1 || m_data !== prev_data) begin
               errors++; $display("FAIL stall_hold c=%0d: got v=%b d=%h expected v=1 d=%h", c, m_valid, m_data, prev_data);
            end
         end
         if (m_valid && m_ready) begin
            checks++; if (m_data !== 16'h0009 + 16'(k)) begin errors++; $display("FAIL stall_data k=%0d: got %h expected %h", k, m_data, 16'h0009 + 16'(k)); end
            checks++; if (m_sof !== (k == 0)) begin errors++; $display("FAIL stall_sof k=%0d: got %b expected %b", k, m_sof, (k == 0)); end
            checks++; if (m_eol !== (k == 3 || k == 7)) begin errors++; $display("FAIL stall_eol k=%0d: got %b expected %b", k, m_eol, (k == 3 || k == 7)); end
            k++;
         end
         if (frame_done) fd_cnt++;
         prev_stall = m_valid & ~m_ready;
         prev_data  = m_data;
      end
      checks++; if (k != 8) begin errors++; $display("FAIL stall_count: got %0d expected 8", k); end
      checks++; if (fd_cnt != 0) begin errors++; $display("FAIL stall_fd_early: got %0d expected 0", fd_cnt); end
      drive(1'b0, 1'b1, 1'b1, 0, 16'h0);
      checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL stall_fd: got %b expected 1", frame_done); end
      checks++; if (m_valid !== 1'b0)    begin errors++; $display("FAIL stall_drained: got %b expected 0", m_valid); end
   endtask

   task automatic test_underrun();
      int k, cyc2, cyc3;
      k = 0; cyc2 = 0; cyc3 = 0;
      for (int c = 0; c < 100 && k < 8; c++) begin
         drive(1'b0, 1'b1, 1'b1, (c == 0) ? 3 : ((c == 12) ? 5 : 0),
               (c == 0) ? 16'h0021 : 16'h0024);
         checks++; if (fifo_ren && fifo_empty) begin errors++; $display("FAIL under_ren_empty c=%0d: got ren=1 expected 0", c); end
         if (c == 8) begin
            checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL under_gap: got %b expected 0", m_valid); end
         end
         if (m_valid && m_ready) begin
            checks++; if (m_data !== 16'h0021 + 16'(k)) begin errors++; $display("FAIL under_data k=%0d: got %h expected %h", k, m_data, 16'h0021 + 16'(k)); end
            checks++; if (m_sof !== (k == 0)) begin errors++; $display("FAIL under_sof k=%0d: got %b expected %b", k, m_sof, (k == 0)); end
            checks++; if (m_eol !== (k == 3 || k == 7)) begin errors++; $display("FAIL under_eol k=%0d: got %b expected %b", k, m_eol, (k == 3 || k == 7)); end
            if (k == 2) cyc2 = c;
            if (k == 3) cyc3 = c;
            k++;
         end
      end
      checks++; if (k != 8) begin errors++; $display("FAIL under_count: got %0d expected 8", k); end
      checks++; if (cyc3 - cyc2 <= 1) begin errors++; $display("FAIL under_gap_len: got %0d expected >1", cyc3 - cyc2); end
      drive(1'b0, 1'b1, 1'b1, 0, 16'h0);
      checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL under_fd: got %b expected 1", frame_done); end
   endtask

   task automatic test_enable_drop();
      int p0, k, k2;
      p0 = pop_cnt; k = 0; k2 = 0;
      drive(1'b0, 1'b1, 1'b0, 8, 16'h0031);
      drive(1'b0, 1'b1, 1'b0, 0, 16'h0);
      drive(1'b0, 1'b1, 1'b0, 0, 16'h0);
      for (int c = 0; c < 10; c++) begin
         drive(1'b0, 1'b0, 1'b1, 0, 16'h0);
         if (c == 0) begin
            checks++; if (pop_cnt - p0 != 3) begin errors++; $display("FAIL en_outstanding: got %0d expected 3", pop_cnt - p0); end
         end
         checks++; if (fifo_ren !== 1'b0) begin errors++; $display("FAIL en_ren_off c=%0d: got %b expected 0", c, fifo_ren); end
         if (m_valid && m_ready) begin
            checks++; if (m_data !== 16'h0031 + 16'(k)) begin errors++; $display("FAIL en_data k=%0d: got %h expected %h", k, m_data, 16'h0031 + 16'(k)); end
            checks++; if (m_sof !== (k == 0)) begin errors++; $display("FAIL en_sof k=%0d: got %b expected %b", k, m_sof, (k == 0)); end
            k++;
         end
      end
      checks++; if (k != 3) begin errors++; $display("FAIL en_drain_count: got %0d expected 3", k); end
      checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL en_drained: got %b expected 0", m_valid); end
      for (int c = 0; c < 40 && k2 < 5; c++) begin
         drive(1'b0, 1'b1, 1'b1, 0, 16'h0);
         if (c == 0) begin
            checks++; if (fifo_ren !== 1'b1) begin errors++; $display("FAIL en_resume_ren: got %b expected 1", fifo_ren); end
         end
         if (m_valid && m_ready) begin
            checks++; if (m_data !== 16'h0034 + 16'(k2)) begin errors++; $display("FAIL en_resume_data k=%0d: got %h expected %h", k2, m_data, 16'h0034 + 16'(k2)); end
            checks++; if (m_eol !== (k2 == 0 || k2 == 4)) begin errors++; $display("FAIL en_resume_eol k=%0d: got %b expected %b", k2, m_eol, (k2 == 0 || k2 == 4)); end
            checks++; if (m_sof !== 1'b0) begin errors++; $display("FAIL en_resume_sof k=%0d: got %b expected 0", k2, m_sof); end
            k2++;
         end
      end
      checks++; if (k2 != 5) begin errors++; $display("FAIL en_resume_count: got %0d expected 5", k2); end
      drive(1'b0, 1'b1, 1'b1, 0, 16'h0);
      checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL en_fd: got %b expected 1", frame_done); end
   endtask

   task automatic test_reset_mid();
      int   p0, k, first;
      logic rdy;
      p0 = pop_cnt; k = 0; first = -1;
      for (int c = 0; c < 6; c++) begin
         rdy = (c < 4);
         drive(1'b0, 1'b1, rdy, (c == 0) ? 8 : 0, 16'h0041);
         if (m_valid && m_ready) begin
            checks++; if (m_data !== 16'h0041 + 16'(k) || m_sof !== (k == 0)) begin
               errors++; $display("FAIL rmid_pre k=%0d: got d=%h sof=%b expected d=%h sof=%b", k, m_data, m_sof, 16'h0041 + 16'(k), (k == 0));
            end
            k++;
         end
      end
      checks++; if (k != 2) begin errors++; $display("FAIL rmid_pre_count: got %0d expected 2", k); end
      drive(1'b1, 1'b1, 1'b0, 0, 16'h0);
      checks++; if (pop_cnt - p0 != 5 || m_valid !== 1'b1) begin
         errors++; $display("FAIL rmid_full: got pops=%0d v=%b expected pops=5 v=1", pop_cnt - p0, m_valid);
      end
      checks++; if (fifo_ren !== 1'b0) begin errors++; $display("FAIL rmid_ren_in_rst: got %b expected 0", fifo_ren); end
      drive(1'b0, 1'b1, 1'b0, 0, 16'h0);
      checks++; if (m_valid !== 1'b0)   begin errors++; $display("FAIL rmid_valid: got %b expected 0", m_valid); end
      checks++; if (m_data !== 16'h0)   begin errors++; $display("FAIL rmid_data: got %h expected 0000", m_data); end
      checks++; if (m_sof !== 1'b0 || m_eol !== 1'b0 || frame_done !== 1'b0) begin
         errors++; $display("FAIL rmid_flags: got sof=%b eol=%b fd=%b expected 0 0 0", m_sof, m_eol, frame_done);
      end
      checks++; if (fifo_ren !== 1'b1) begin errors++; $display("FAIL rmid_ren_after: got %b expected 1", fifo_ren); end
      k = 0;
      for (int c = 0; c < 30 && k < 3; c++) begin
         drive(1'b0, 1'b1, 1'b1, 0, 16'h0);
         if (m_valid && m_ready) begin
            if (k == 0) first = c;
            checks++; if (m_data !== 16'h0046 + 16'(k)) begin errors++; $display("FAIL rmid_data_k%0d: got %h expected %h", k, m_data, 16'h0046 + 16'(k)); end
            checks++; if (m_sof !== (k == 0)) begin errors++; $display("FAIL rmid_sof k=%0d: got %b expected %b", k, m_sof, (k == 0)); end
            k++;
         end
      end
      checks++; if (k != 3) begin errors++; $display("FAIL rmid_post_count: got %0d expected 3", k); end
      checks++; if (first != 1) begin errors++; $display("FAIL rmid_latency: got %0d expected 1", first); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst     = 1'b1;
      enable  = 1'b0;
      m_ready = 1'b0;
      test_reset();
      test_stream();
      test_stall();
      test_underrun();
      test_enable_drop();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
